// File: rtl/fir4_mac_datapath.sv
`default_nettype none
// ============================================================================
// Module   : fir4_mac_datapath
// Purpose  : 4-tap signed FIR multiply-accumulate datapath driven by a
//            4-state frame controller (tap select, load and clear strobes).
// Revision : 1.0 - initial release
// ============================================================================
module fir4_mac_datapath #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int ACC_W  = DATA_W + COEF_W + 2
) (
    input  logic                     ph1,
    input  logic                     reset,
    input  logic [1:0]               mux_control,
    input  logic                     data_load,
    input  logic                     clear_accum,
    input  logic signed [DATA_W-1:0] sample_in,
    input  logic                     coef_we,
    input  logic [1:0]               coef_addr,
    input  logic signed [COEF_W-1:0] coef_data,
    output logic signed [ACC_W-1:0]  result_out,
    output logic                     out_valid
);

    localparam int         PROD_W  = DATA_W + COEF_W;
    localparam int         GUARD_W = ACC_W - PROD_W;
    localparam logic [2:0] c_FULL  = 3'd4;

    logic signed [DATA_W-1:0] r_taps [0:3];
    logic signed [COEF_W-1:0] r_coef [0:3];
    logic signed [ACC_W-1:0]  r_acc;
    logic [2:0]               r_fill_cnt;
    logic signed [ACC_W-1:0]  r_result;
    logic                     r_valid;

    logic signed [DATA_W-1:0] w_tap;
    logic signed [COEF_W-1:0] w_coef;
    logic signed [PROD_W-1:0] w_tap_ext;
    logic signed [PROD_W-1:0] w_coef_ext;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_prod_ext;
    logic signed [ACC_W-1:0]  w_sum;
    logic                     w_capture;

    // Operands are widened to the full product width first so the multiply
    // is exact and signed without relying on context-width rules.
    assign w_tap      = r_taps[mux_control];
    assign w_coef     = r_coef[mux_control];
    assign w_tap_ext  = {{COEF_W{w_tap[DATA_W-1]}}, w_tap};
    assign w_coef_ext = {{DATA_W{w_coef[COEF_W-1]}}, w_coef};
    assign w_prod     = w_tap_ext * w_coef_ext;
    assign w_prod_ext = {{GUARD_W{w_prod[PROD_W-1]}}, w_prod};
    assign w_sum      = r_acc + w_prod_ext;
    assign w_capture  = clear_accum && (r_fill_cnt == c_FULL);

    always_ff @(posedge ph1 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                r_taps[i] <= '0;
                r_coef[i] <= '0;
            end
            r_acc      <= '0;
            r_fill_cnt <= '0;
            r_result   <= '0;
            r_valid    <= 1'b0;
        end else begin
            r_acc   <= clear_accum ? '0 : w_sum;
            r_valid <= w_capture;
            if (w_capture) begin
                r_result <= w_sum;
            end
            // Shift happens after this edge; the sum above saw the old taps.
            if (data_load) begin
                r_taps[0] <= sample_in;
                for (int i = 1; i < 4; i++) begin
                    r_taps[i] <= r_taps[i-1];
                end
                if (r_fill_cnt != c_FULL) begin
                    r_fill_cnt <= r_fill_cnt + 3'd1;
                end
            end
            if (coef_we) begin
                r_coef[coef_addr] <= coef_data;
            end
        end
    end

    assign result_out = r_result;
    assign out_valid  = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_fir4_mac_datapath.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir4_mac_datapath
// Purpose  : Directed self-checking bench for fir4_mac_datapath.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir4_mac_datapath;

    localparam int DATA_W = 8;
    localparam int COEF_W = 8;
    localparam int ACC_W  = DATA_W + COEF_W + 2;

    logic                     ph1;
    logic                     reset;
    logic [1:0]               mux_control;
    logic                     data_load;
    logic                     clear_accum;
    logic signed [DATA_W-1:0] sample_in;
    logic                     coef_we;
    logic [1:0]               coef_addr;
    logic signed [COEF_W-1:0] coef_data;
    logic signed [ACC_W-1:0]  result_out;
    logic                     out_valid;

    int n_tests = 0;
    int n_fail  = 0;

    fir4_mac_datapath #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .ACC_W  (ACC_W)
    ) u_dut (
        .ph1         (ph1),
        .reset       (reset),
        .mux_control (mux_control),
        .data_load   (data_load),
        .clear_accum (clear_accum),
        .sample_in   (sample_in),
        .coef_we     (coef_we),
        .coef_addr   (coef_addr),
        .coef_data   (coef_data),
        .result_out  (result_out),
        .out_valid   (out_valid)
    );

    initial ph1 = 1'b0;
    always #5 ph1 = ~ph1;

    task automatic chk(input string tag, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic cyc(input logic [1:0] sel, input logic ld, input logic clr,
                       input logic signed [DATA_W-1:0] s);
        mux_control = sel;
        data_load   = ld;
        clear_accum = clr;
        sample_in   = s;
        @(posedge ph1);
        #1;
        coef_we = 1'b0;
    endtask

    // Each write also clears the accumulator so stale products never leak.
    task automatic write_coefs(input int c0, input int c1, input int c2, input int c3);
        int cv [4];
        cv = '{c0, c1, c2, c3};
        for (int i = 0; i < 4; i++) begin
            coef_we   = 1'b1;
            coef_addr = 2'(i);
            coef_data = COEF_W'(cv[i]);
            cyc(2'(i), 1'b0, 1'b1, '0);
        end
    endtask

    // Controller frame: sel 0..3, clear on sel 3, optional load on sel 3,
    // optional write of coef[2]=0 during the sel 2 cycle.
    task automatic frame(input logic ld, input int s, input logic cw2);
        cyc(2'd0, 1'b0, 1'b0, '0);
        chk("valid_drop", int'(out_valid), 0);
        cyc(2'd1, 1'b0, 1'b0, '0);
        if (cw2) begin
            coef_we   = 1'b1;
            coef_addr = 2'd2;
            coef_data = '0;
        end
        cyc(2'd2, 1'b0, 1'b0, '0);
        cyc(2'd3, ld, 1'b1, DATA_W'(s));
    endtask

    initial begin
        reset       = 1'b1;
        mux_control = '0;
        data_load   = 1'b0;
        clear_accum = 1'b0;
        sample_in   = '0;
        coef_we     = 1'b0;
        coef_addr   = '0;
        coef_data   = '0;
        repeat (2) @(posedge ph1);
        #1;
        chk("rst_result", int'(result_out), 0);
        chk("rst_valid", int'(out_valid), 0);
        reset = 1'b0;

        // Fill and first output
        write_coefs(1, 2, 3, 4);
        for (int f = 1; f <= 4; f++) begin
            frame(1'b1, f * 10, 1'b0);
            chk("fill_no_valid", int'(out_valid), 0);
        end
        frame(1'b1, 50, 1'b0);
        chk("first_valid", int'(out_valid), 1);
        chk("first_result", int'(result_out), 200);
        frame(1'b1, 60, 1'b0);
        chk("second_valid", int'(out_valid), 1);
        chk("second_result", int'(result_out), 300);

        // Extreme values
        write_coefs(-128, -128, -128, -128);
        repeat (4) frame(1'b1, -128, 1'b0);
        frame(1'b1, -128, 1'b0);
        chk("ext_negneg", int'(result_out), 65536);
        write_coefs(127, 127, 127, 127);
        frame(1'b0, 0, 1'b0);
        chk("ext_posneg", int'(result_out), -65024);

        // Coefficient write collision with steady taps 40,30,20,10
        write_coefs(1, 2, 3, 4);
        for (int f = 1; f <= 4; f++) frame(1'b1, f * 10, 1'b0);
        frame(1'b0, 0, 1'b0);
        chk("steady", int'(result_out), 200);
        frame(1'b0, 0, 1'b1);
        chk("coll_old", int'(result_out), 200);
        frame(1'b0, 0, 1'b0);
        chk("coll_new", int'(result_out), 140);
        write_coefs(1, 2, 3, 4);

        // No clear for 8 cycles: acc reaches 400, output held
        frame(1'b0, 0, 1'b0);
        chk("pre_noclr", int'(result_out), 200);
        for (int c = 0; c < 8; c++) begin
            cyc(2'(c % 4), 1'b0, 1'b0, '0);
            chk("noclr_valid", int'(out_valid), 0);
            chk("noclr_hold", int'(result_out), 200);
        end
        cyc(2'd0, 1'b0, 1'b1, '0);
        chk("noclr_acc", int'(result_out), 440);

        // Load without clear mid-frame
        cyc(2'd0, 1'b0, 1'b0, '0);
        cyc(2'd1, 1'b1, 1'b0, 8'sd7);
        cyc(2'd2, 1'b0, 1'b0, '0);
        cyc(2'd3, 1'b0, 1'b1, '0);
        chk("midload_valid", int'(out_valid), 1);
        chk("midload_result", int'(result_out), 270);
        frame(1'b0, 0, 1'b0);
        chk("post_midload", int'(result_out), 257);
        chk("post_midload_v", int'(out_valid), 1);

        // Reset mid-frame
        cyc(2'd0, 1'b0, 1'b0, '0);
        mux_control = 2'd1;
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_result", int'(result_out), 0);
        chk("mid_rst_valid", int'(out_valid), 0);
        @(posedge ph1);
        #1;
        reset = 1'b0;
        write_coefs(1, 2, 3, 4);
        for (int f = 1; f <= 4; f++) begin
            frame(1'b1, f, 1'b0);
            chk("refill_no_valid", int'(out_valid), 0);
            chk("refill_hold", int'(result_out), 0);
        end
        frame(1'b1, 5, 1'b0);
        chk("refill_valid", int'(out_valid), 1);
        chk("refill_result", int'(result_out), 20);
        cyc(2'd0, 1'b0, 1'b0, '0);
        chk("refill_pulse_end", int'(out_valid), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
